// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared constants, engine state type and proxy hash for the miner bring-up top
package miner_pkg;

    localparam int CLK_HZ_DEFAULT = 100000000;
    localparam int BAUD_DEFAULT   = 115200;
    localparam int WORK_BYTES     = 44;
    localparam int BYTE_CNT_W     = $clog2(WORK_BYTES);
    localparam int TX_IDX_W       = 2;
    localparam logic [31:0] HASH_MULT = 32'h9E3779B1;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_SCAN = 2'd1,
        ENG_HOLD = 2'd2
    } engine_state_t;

    // Stand-in for the SHA-256 pipeline so the serial protocol can be exercised alone.
    function automatic logic [31:0] proxy_hash(input logic [31:0] nonce,
                                               input logic [31:0] w0,
                                               input logic [31:0] d2);
        return (nonce * HASH_MULT) ^ w0 ^ d2;
    endfunction

endpackage

// File: rtl/miner_uart.sv
// rtl/miner_uart.sv - 8N1 UART: synchronised receiver with byte strobe, serialiser with ready handshake
module miner_uart #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_tdata,
    output logic       rx_tvalid,
    input  logic [7:0] tx_tdata,
    input  logic       tx_tvalid,
    output logic       tx_tready
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_END = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic             rx_meta, rx_s, rx_prev;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_tdata  <= '0;
            rx_tvalid <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            rx_tvalid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    // True falling edge, so a line held low after a framing error is not re-read.
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL_END) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == FULL_END) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s) begin
                            rx_tdata  <= rx_shift;
                            rx_tvalid <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    logic             tx_busy;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic [8:0]       tx_shift;
    logic             tx_last;

    // Accepting in the final stop-bit cycle keeps back-to-back bytes gapless.
    assign tx_last   = tx_busy && (tx_cnt == FULL_END) && (tx_bit == 4'd9);
    assign tx_tready = !tx_busy || tx_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
        end else if (tx_tvalid && tx_tready) begin
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= {1'b1, tx_tdata};
        end else if (tx_busy) begin
            if (tx_cnt == FULL_END) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx       <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_bit   <= tx_bit + 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/top.sv
// rtl/top.sv - miner bring-up top: UART work packets, proxy-hash nonce scan, golden nonce reply (option MINER_RX_TIMEOUT_EN)
module top import miner_pkg::*; #(
    parameter int CLK_HZ    = CLK_HZ_DEFAULT,
    parameter int BAUD      = BAUD_DEFAULT,
    parameter int ZERO_BITS = 20
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rx,
    output logic tx
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int SH_W         = (WORK_BYTES - 1) * 8;

    logic [7:0] rx_tdata, tx_tdata;
    logic       rx_tvalid, tx_tvalid, tx_tready;

    miner_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk       (clk_in),
        .rst       (rst_in),
        .rx        (rx),
        .tx        (tx),
        .rx_tdata  (rx_tdata),
        .rx_tvalid (rx_tvalid),
        .tx_tdata  (tx_tdata),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready)
    );

    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [SH_W-1:0]       shadow;
    logic [31:0]           work_w0, work_d2;
    logic                  pkt_done, rx_timeout;

    assign pkt_done = rx_tvalid && (byte_cnt == BYTE_CNT_W'(WORK_BYTES - 1));

`ifdef MINER_RX_TIMEOUT_EN
    localparam int TO_CYCLES = CLK_HZ / 100;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt;

    assign rx_timeout = (idle_cnt == TO_W'(TO_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in || rx_tvalid || byte_cnt == '0) idle_cnt <= '0;
        else if (!rx_timeout) idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign rx_timeout = 1'b0;
`endif

    // Shadow holds bytes 0..42; the 44th byte completes the active work directly.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            byte_cnt <= '0;
            shadow   <= '0;
            work_w0  <= '0;
            work_d2  <= '0;
        end else if (rx_tvalid) begin
            shadow   <= {shadow[SH_W-9:0], rx_tdata};
            byte_cnt <= pkt_done ? '0 : byte_cnt + 1'b1;
            if (pkt_done) begin
                work_w0 <= shadow[SH_W-1 -: 32];
                work_d2 <= {shadow[23:0], rx_tdata};
            end
        end else if (rx_timeout) begin
            byte_cnt <= '0;
        end
    end

    engine_state_t         state;
    logic [31:0]           nonce, result, hash;
    logic                  golden, sending, tx_idle;
    logic [TX_IDX_W-1:0]   tx_idx;

    assign hash      = proxy_hash(nonce, work_w0, work_d2);
    assign golden    = (hash >> (32 - ZERO_BITS)) == 32'd0;
    assign tx_idle   = !sending && tx_tready;
    assign tx_tvalid = sending;
    // Byte index 0 selects bits 31:24, index 3 selects bits 7:0.
    assign tx_tdata  = result[{~tx_idx, 3'b111} -: 8];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= ENG_IDLE;
            nonce   <= '0;
            result  <= '0;
            sending <= 1'b0;
            tx_idx  <= '0;
        end else begin
            if (sending && tx_tready) begin
                tx_idx <= tx_idx + 1'b1;
                if (tx_idx == TX_IDX_W'(3)) sending <= 1'b0;
            end
            if (pkt_done) begin
                state <= ENG_SCAN;
                nonce <= '0;
            end else begin
                case (state)
                    ENG_SCAN: begin
                        if (golden) begin
                            if (tx_idle) begin
                                result  <= nonce;
                                sending <= 1'b1;
                                tx_idx  <= '0;
                                state   <= ENG_IDLE;
                            end else begin
                                state <= ENG_HOLD;
                            end
                        end else if (nonce == 32'hFFFF_FFFF) begin
                            state <= ENG_IDLE;
                        end else begin
                            nonce <= nonce + 32'd1;
                        end
                    end
                    ENG_HOLD: begin
                        if (tx_idle) begin
                            result  <= nonce;
                            sending <= 1'b1;
                            tx_idx  <= '0;
                            state   <= ENG_IDLE;
                        end
                    end
                    default: state <= ENG_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - self-checking bench for top: UART work packets against a first-golden-nonce model
module tb_top;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int ZB     = 8;
    localparam int CPB    = CLK_HZ / BAUD;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rx     = 1'b1;
    logic tx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_stop_cyc = 0;
    bit mon_en   = 1'b0;
    logic [7:0] tx_bytes[$];
    int         tx_starts[$];
    logic [7:0] pkt[44];

    top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ZERO_BITS(ZB)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rx     (rx),
        .tx     (tx)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Line monitor: decodes every frame on tx at bit centres.
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk_in);
            if (tx === 1'b0) begin
                int t;
                logic [7:0] b;
                t = cyc;
                b = '0;
                repeat (CPB / 2) @(negedge clk_in);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_in);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk_in);
                tx_bytes.push_back(b);
                tx_starts.push_back(t);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        last_stop_cyc = cyc;
        rx = good_stop;
        tick(CPB);
        if (!good_stop) begin
            rx = 1'b1;
            tick(CPB);
        end
    endtask

    task automatic send_pkt(input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(pkt[i], 1'b1);
    endtask

    task automatic clear_pkt();
        for (int i = 0; i < 44; i++) pkt[i] = 8'h00;
    endtask

    // Model: the smallest nonce whose hash has ZB leading zero bits; -1 if beyond the search bound.
    function automatic int first_golden(input logic [31:0] w0, input logic [31:0] d2);
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] h;
            h = (32'(n) * 32'h9E3779B1) ^ w0 ^ d2;
            if ((h >> (32 - ZB)) == 32'd0) return n;
        end
        return -1;
    endfunction

    task automatic expect_reply(input string tag, input logic [31:0] exp, output int first_start);
        int waited;
        waited = 0;
        first_start = -1;
        while (tx_bytes.size() < 4 && waited < 20000) begin
            tick(1);
            waited++;
        end
        tick(30 * CPB);
        check({tag, "_bytes"}, tx_bytes.size(), 32'd4);
        if (tx_bytes.size() >= 4) begin
            first_start = tx_starts[0];
            check({tag, "_value"}, {tx_bytes[0], tx_bytes[1], tx_bytes[2], tx_bytes[3]}, exp);
        end
        tx_bytes.delete();
        tx_starts.delete();
    endtask

    initial begin
        int fs;
        int lat;
        int exp_n;
        logic [31:0] w0, d2;

        tick(5);
        check("reset_tx", tx, 1'b1);
        rst_in = 1'b0;
        mon_en = 1'b1;

        tick(CLK_HZ / 1000);
        check("idle_no_start", tx_bytes.size(), 32'd0);
        check("idle_tx_high", tx, 1'b1);

        clear_pkt();
        send_pkt(0, 43);
        expect_reply("zero_pkt", 32'h0000_0000, fs);
        lat = fs - last_stop_cyc;
        checks++;
        assert (fs >= 0 && lat <= CPB / 2 + 7) else begin
            failures++;
            $error("FAIL zero_pkt_latency: observed=%0d cycles required<=%0d", lat, CPB / 2 + 7);
        end

        clear_pkt();
        pkt[0] = 8'h9E; pkt[1] = 8'h37; pkt[2] = 8'h79; pkt[3] = 8'hB1;
        send_pkt(0, 43);
        expect_reply("mult_pkt", 32'h0000_0001, fs);

        clear_pkt();
        send_pkt(0, 42);
        tick(300);
        check("partial_silent", tx_bytes.size(), 32'd0);
        rst_in = 1'b1;
        tick(3);
        rst_in = 1'b0;
        tick(2);
        send_pkt(0, 43);
        expect_reply("after_reset", 32'h0000_0000, fs);

        clear_pkt();
        for (int i = 0; i < 44; i++) send_byte(pkt[i], i != 10);
        tick(300);
        check("framing_silent", tx_bytes.size(), 32'd0);
        send_byte(8'h00, 1'b1);
        expect_reply("framing_extra", 32'h0000_0000, fs);

        for (int k = 0; k < 3; k++) begin
            do begin
                for (int i = 0; i < 44; i++) pkt[i] = 8'($urandom);
                w0 = {pkt[0], pkt[1], pkt[2], pkt[3]};
                d2 = {pkt[40], pkt[41], pkt[42], pkt[43]};
                exp_n = first_golden(w0, d2);
            end while (exp_n < 0);
            send_pkt(0, 43);
            expect_reply($sformatf("rand%0d", k), 32'(exp_n), fs);
        end

        clear_pkt();
        pkt[0] = 8'h9E; pkt[1] = 8'h37; pkt[2] = 8'h79; pkt[3] = 8'hB1;
        send_pkt(0, 19);
        tick(11 * CLK_HZ / 1000);
        clear_pkt();
        send_pkt(0, 43);
`ifdef MINER_RX_TIMEOUT_EN
        expect_reply("gap_resync", 32'h0000_0000, fs);
`else
        expect_reply("gap_persist", 32'h0000_0001, fs);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
